// File: rtl/flash_block_fetcher.sv
// Block fetcher: streams DEPTH 16-bit words from an external source into a
// buffer memory, raises an interrupt per completed block, and waits for a CPU
// acknowledge before refilling. The first and last words of the last completed
// block are held on two output ports.
module flash_block_fetcher #(
   parameter int unsigned DEPTH      = 8,
   parameter logic [15:0] START_ADDR = 16'h5000,
   parameter logic [15:0] ACK_ADDR   = 16'h5001
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Write_IO,
   input  logic [15:0] FLASH_data,
   input  logic [15:0] Adress_bus,
   output logic        get_data,
   output logic        Interrupt_en,
   output logic [15:0] buffermem_out1,
   output logic [15:0] buffermem_out2
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StGap,
      StWaitAck
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] index_q, index_d;
   logic [15:0]     mem_q [DEPTH];
   logic            get_data_q;
   logic            int_q;
   logic [15:0]     out1_q, out1_d;
   logic [15:0]     out2_q, out2_d;
   logic            start;
   logic            ack;

   assign start = Write_IO && (Adress_bus == START_ADDR);
   assign ack   = Write_IO && (Adress_bus == ACK_ADDR);

   // Next-state logic: one request cycle plus one gap cycle per word.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      out1_d  = out1_q;
      out2_d  = out2_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StReq;
               index_d = '0;
            end
         end
         StReq: begin
            if (index_q < LastIdx) begin
               index_d = index_q + 1'b1;
               state_d = StGap;
            end else begin
               // Last word bypasses the memory; it is written on this same edge.
               state_d = StWaitAck;
               out1_d  = mem_q[0];
               out2_d  = FLASH_data;
            end
         end
         StGap: begin
            state_d = StReq;
         end
         StWaitAck: begin
            if (ack) begin
               state_d = StReq;
               index_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; outputs decode the next state so they are registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         index_q    <= '0;
         get_data_q <= 1'b0;
         int_q      <= 1'b0;
         out1_q     <= '0;
         out2_q     <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         get_data_q <= (state_d == StReq);
         int_q      <= (state_d == StWaitAck);
         out1_q     <= out1_d;
         out2_q     <= out2_d;
      end
   end

   // Buffer capture: the source word is valid at the edge closing a request cycle.
   always_ff @(posedge clock) begin
      if (!reset && (state_q == StReq)) begin
         mem_q[index_q] <= FLASH_data;
      end
   end

   assign get_data       = get_data_q;
   assign Interrupt_en   = int_q;
   assign buffermem_out1 = out1_q;
   assign buffermem_out2 = out2_q;

endmodule

// File: tb/tb_flash_block_fetcher.sv
// Directed testbench for flash_block_fetcher (DEPTH = 8).
module tb_flash_block_fetcher;

   logic        clock;
   logic        reset;
   logic        Write_IO;
   logic [15:0] FLASH_data;
   logic [15:0] Adress_bus;
   logic        get_data;
   logic        Interrupt_en;
   logic [15:0] buffermem_out1;
   logic [15:0] buffermem_out2;

   int          n_checks;
   int          n_fails;

   // Source model state: word n of a block is src_base + n * src_step.
   logic [15:0] src_base;
   logic [15:0] src_step;
   int          pulse_cnt;

   flash_block_fetcher #(
      .DEPTH      (8),
      .START_ADDR (16'h5000),
      .ACK_ADDR   (16'h5001)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .Write_IO       (Write_IO),
      .FLASH_data     (FLASH_data),
      .Adress_bus     (Adress_bus),
      .get_data       (get_data),
      .Interrupt_en   (Interrupt_en),
      .buffermem_out1 (buffermem_out1),
      .buffermem_out2 (buffermem_out2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to the next falling edge; answer a visible request with the next word.
   task automatic tick();
      @(negedge clock);
      if (get_data === 1'b1) begin
         FLASH_data = src_base + 16'(pulse_cnt) * src_step;
         pulse_cnt++;
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      Write_IO   = 1'b0;
      Adress_bus = 16'h0000;
      FLASH_data = 16'h0000;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({get_data, Interrupt_en} !== 2'b00 || buffermem_out1 !== 16'h0 ||
          buffermem_out2 !== 16'h0) begin
         $display("FAIL reset_outputs: got gd=%b int=%b o1=%h o2=%h, want 0 0 0000 0000",
                  get_data, Interrupt_en, buffermem_out1, buffermem_out2);
         n_fails++;
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         n_checks++;
         if (get_data !== 1'b0 || Interrupt_en !== 1'b0) begin
            $display("FAIL reset_idle cycle %0d: got gd=%b int=%b, want 0 0",
                     k, get_data, Interrupt_en);
            n_fails++;
         end
      end
   endtask

   // Start held 3 cycles; one block of 0x1111..0x8888 with the interrupt 15 edges later.
   task automatic test_start_capture();
      logic exp_gd;
      logic exp_int;
      src_base   = 16'h1111;
      src_step   = 16'h1111;
      pulse_cnt  = 0;
      Write_IO   = 1'b1;
      Adress_bus = 16'h5000;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 3) Write_IO = 1'b0;
         exp_gd  = (k <= 15) && (k % 2 == 1);
         exp_int = (k >= 16);
         n_checks++;
         if (get_data !== exp_gd || Interrupt_en !== exp_int) begin
            $display("FAIL start_timing k=%0d: got gd=%b int=%b, want gd=%b int=%b",
                     k, get_data, Interrupt_en, exp_gd, exp_int);
            n_fails++;
         end
         if (k == 15) begin
            n_checks++;
            if (buffermem_out1 !== 16'h0 || buffermem_out2 !== 16'h0) begin
               $display("FAIL start_outputs_early: got o1=%h o2=%h, want 0000 0000",
                        buffermem_out1, buffermem_out2);
               n_fails++;
            end
         end
      end
      n_checks++;
      if (buffermem_out1 !== 16'h1111 || buffermem_out2 !== 16'h8888) begin
         $display("FAIL capture_first_last: got o1=%h o2=%h, want 1111 8888",
                  buffermem_out1, buffermem_out2);
         n_fails++;
      end
      n_checks++;
      if (pulse_cnt !== 8) begin
         $display("FAIL start_pulse_count: got %0d, want 8", pulse_cnt);
         n_fails++;
      end
   endtask

   // Without an ack the block stays parked; stray and start writes are ignored.
   task automatic test_no_ack();
      for (int k = 0; k < 50; k++) begin
         Write_IO   = (k == 10) || (k == 20);
         Adress_bus = (k == 10) ? 16'h5002 : 16'h5000;
         tick();
         n_checks++;
         if (get_data !== 1'b0 || Interrupt_en !== 1'b1 || buffermem_out1 !== 16'h1111 ||
             buffermem_out2 !== 16'h8888) begin
            $display("FAIL no_ack k=%0d: got gd=%b int=%b o1=%h o2=%h, want 0 1 1111 8888",
                     k, get_data, Interrupt_en, buffermem_out1, buffermem_out2);
            n_fails++;
         end
      end
      Write_IO = 1'b0;
   endtask

   // Ack held 2 cycles; the next block starts at once and the old words stay visible.
   task automatic test_ack();
      logic exp_gd;
      logic exp_int;
      src_base   = 16'hA000;
      src_step   = 16'h0001;
      pulse_cnt  = 0;
      Write_IO   = 1'b1;
      Adress_bus = 16'h5001;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 2) Write_IO = 1'b0;
         exp_gd  = (k <= 15) && (k % 2 == 1);
         exp_int = (k >= 16);
         n_checks++;
         if (get_data !== exp_gd || Interrupt_en !== exp_int) begin
            $display("FAIL ack_timing k=%0d: got gd=%b int=%b, want gd=%b int=%b",
                     k, get_data, Interrupt_en, exp_gd, exp_int);
            n_fails++;
         end
         if (k <= 15) begin
            n_checks++;
            if (buffermem_out1 !== 16'h1111 || buffermem_out2 !== 16'h8888) begin
               $display("FAIL ack_outputs_hold k=%0d: got o1=%h o2=%h, want 1111 8888",
                        k, buffermem_out1, buffermem_out2);
               n_fails++;
            end
         end
      end
      n_checks++;
      if (buffermem_out1 !== 16'hA000 || buffermem_out2 !== 16'hA007) begin
         $display("FAIL ack_second_block: got o1=%h o2=%h, want a000 a007",
                  buffermem_out1, buffermem_out2);
         n_fails++;
      end
   endtask

   // Reset after the 4th request aborts the block; a fresh start gives a full block.
   task automatic test_reset_mid_block();
      logic exp_gd;
      logic exp_int;
      // Ack to start a block that will be aborted.
      src_base   = 16'h5555;
      src_step   = 16'h0001;
      pulse_cnt  = 0;
      Write_IO   = 1'b1;
      Adress_bus = 16'h5001;
      tick();
      Write_IO = 1'b0;
      for (int k = 0; k < 30 && pulse_cnt < 4; k++) tick();
      n_checks++;
      if (pulse_cnt !== 4) begin
         $display("FAIL midreset_pulses: got %0d, want 4", pulse_cnt);
         n_fails++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({get_data, Interrupt_en} !== 2'b00 || buffermem_out1 !== 16'h0 ||
          buffermem_out2 !== 16'h0) begin
         $display("FAIL midreset_outputs: got gd=%b int=%b o1=%h o2=%h, want 0 0 0000 0000",
                  get_data, Interrupt_en, buffermem_out1, buffermem_out2);
         n_fails++;
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         n_checks++;
         if (get_data !== 1'b0 || Interrupt_en !== 1'b0) begin
            $display("FAIL midreset_idle k=%0d: got gd=%b int=%b, want 0 0",
                     k, get_data, Interrupt_en);
            n_fails++;
         end
      end
      src_base   = 16'h3000;
      src_step   = 16'h0101;
      pulse_cnt  = 0;
      Write_IO   = 1'b1;
      Adress_bus = 16'h5000;
      for (int k = 1; k <= 16; k++) begin
         tick();
         Write_IO = 1'b0;
         exp_gd  = (k <= 15) && (k % 2 == 1);
         exp_int = (k >= 16);
         n_checks++;
         if (get_data !== exp_gd || Interrupt_en !== exp_int) begin
            $display("FAIL restart_timing k=%0d: got gd=%b int=%b, want gd=%b int=%b",
                     k, get_data, Interrupt_en, exp_gd, exp_int);
            n_fails++;
         end
      end
      n_checks++;
      if (buffermem_out1 !== 16'h3000 || buffermem_out2 !== 16'h3707) begin
         $display("FAIL restart_block: got o1=%h o2=%h, want 3000 3707",
                  buffermem_out1, buffermem_out2);
         n_fails++;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      src_base  = 16'h0;
      src_step  = 16'h0;
      pulse_cnt = 0;
      test_reset();
      test_start_capture();
      test_no_ack();
      test_ack();
      test_reset_mid_block();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
